// File: rtl/mem_access_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_wb_stage
// Purpose  : Memory stage plus MEM/WB pipeline register. Takes the EX/MEM
//            register contents, performs loads/stores over a req/ack data
//            memory port, stalls upstream while an access is outstanding,
//            and registers the write-back value, rd index and regwrite.
// Ports    : clk, rst (sync, active-high)
//            EX/MEM inputs  : valid_in, memtoreg/memread/memwrite/regwrite,
//                             AJ select, ALU result, store data, PC+4,
//                             PC+imm, rd index, funct3
//            Data memory    : dmem_req/we/addr/wdata/be out,
//                             dmem_rdata/dmem_ack in
//            Control out    : mem_stall (comb), bus_err (1-cycle pulse)
//            MEM/WB out     : valid_out, regwrite_MEMEX_out, WData_MEM_out,
//                             writingData_MEMWB
// Params   : ACK_TIMEOUT - cycles dmem_req may wait for dmem_ack (>=2)
// Options  : MISALIGN_TRAP_EN - adds misalign_trap output; misaligned
//            half/word accesses trap instead of issuing a request.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_wb_stage #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        memtoreg_MEMEX_out,
    input  logic        memread_MEMEX_out,
    input  logic        memwrite_MEMEX_out,
    input  logic        regwrite_MEMEX_out2,
    input  logic [1:0]  AJ_control_MEMEX_out,
    input  logic [31:0] ALU_result_MEMEX_out,
    input  logic [31:0] readdata2_MEMEX_out,
    input  logic [31:0] adder1_IDEX_MEM,
    input  logic [31:0] adder2_MEM,
    input  logic [4:0]  WData_MEMEX_out,
    input  logic [3:0]  function3_out_MEMEX_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        mem_stall,
    output logic        bus_err,
    output logic        valid_out,
    output logic        regwrite_MEMEX_out,
    output logic [4:0]  WData_MEM_out,
    output logic [31:0] writingData_MEMWB
`ifdef MISALIGN_TRAP_EN
    ,
    output logic        misalign_trap
`endif
);

    localparam int                 c_CNT_W    = $clog2(ACK_TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [c_CNT_W-1:0] r_cnt;

    logic        w_memop;
    logic        w_issue;
    logic        w_retire;
    logic        w_timeout;
    logic [2:0]  w_f3;
    logic [1:0]  w_lo;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_alt;
    logic [31:0] w_wb_data;
    logic        w_unused;

    assign w_f3     = function3_out_MEMEX_out[2:0];
    assign w_unused = function3_out_MEMEX_out[3];
    assign w_lo     = ALU_result_MEMEX_out[1:0];
    assign w_memop  = valid_in & (memread_MEMEX_out | memwrite_MEMEX_out);

`ifdef MISALIGN_TRAP_EN
    logic w_misalign;
    logic w_trap;
    assign w_misalign = (((w_f3 == 3'b001) || (w_f3 == 3'b101)) && w_lo[0])
                      || ((w_f3 == 3'b010) && (w_lo != 2'b00));
`endif

    // Next-state and control decode
    always_comb begin
        w_state_next = r_state;
        mem_stall    = 1'b0;
        w_issue      = 1'b0;
        w_retire     = 1'b0;
        w_timeout    = 1'b0;
`ifdef MISALIGN_TRAP_EN
        w_trap       = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_memop) begin
`ifdef MISALIGN_TRAP_EN
                    if (w_misalign)
                        w_trap = 1'b1;
                    else
`endif
                    begin
                        w_issue      = 1'b1;
                        mem_stall    = 1'b1;
                        w_state_next = S_REQ;
                    end
                end else if (valid_in) begin
                    w_retire = 1'b1;
                end
            end
            S_REQ: begin
                // An ack in the last allowed cycle still completes the access.
                if (dmem_ack) begin
                    w_retire     = 1'b1;
                    w_state_next = S_IDLE;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    mem_stall = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Store lane steering; loads request the whole word
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = readdata2_MEMEX_out;
        if (memwrite_MEMEX_out) begin
            case (w_f3)
                3'b000: begin
                    w_be    = 4'b0001 << w_lo;
                    w_wdata = {4{readdata2_MEMEX_out[7:0]}};
                end
                3'b001: begin
                    w_be    = 4'b0011 << {w_lo[1], 1'b0};
                    w_wdata = {2{readdata2_MEMEX_out[15:0]}};
                end
                3'b010:  w_be = 4'b1111;
                default: w_be = 4'b0000;
            endcase
        end else begin
            w_be = 4'b1111;
        end
    end

    // Load lane extraction; inputs are held by upstream until the ack edge
    always_comb begin
        case (w_lo)
            2'b00:   w_byte = dmem_rdata[7:0];
            2'b01:   w_byte = dmem_rdata[15:8];
            2'b10:   w_byte = dmem_rdata[23:16];
            default: w_byte = dmem_rdata[31:24];
        endcase
        w_half = w_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (w_f3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load = {24'd0, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = dmem_rdata;
        endcase
        case (AJ_control_MEMEX_out)
            2'b01:   w_alt = adder1_IDEX_MEM;
            2'b10:   w_alt = adder2_MEM;
            default: w_alt = ALU_result_MEMEX_out;
        endcase
        w_wb_data = memtoreg_MEMEX_out ? w_load : w_alt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt              <= '0;
            dmem_req           <= 1'b0;
            dmem_we            <= 1'b0;
            dmem_addr          <= 32'd0;
            dmem_wdata         <= 32'd0;
            dmem_be            <= 4'd0;
            bus_err            <= 1'b0;
            valid_out          <= 1'b0;
            regwrite_MEMEX_out <= 1'b0;
            WData_MEM_out      <= 5'd0;
            writingData_MEMWB  <= 32'd0;
`ifdef MISALIGN_TRAP_EN
            misalign_trap      <= 1'b0;
`endif
        end else begin
            r_cnt    <= (r_state == S_REQ) ? r_cnt + 1'b1 : '0;
            dmem_req <= (w_state_next == S_REQ);
            bus_err  <= w_timeout;
`ifdef MISALIGN_TRAP_EN
            misalign_trap <= w_trap;
`endif
            if (w_issue) begin
                dmem_we    <= memwrite_MEMEX_out;
                dmem_addr  <= {ALU_result_MEMEX_out[31:2], 2'b00};
                dmem_wdata <= w_wdata;
                dmem_be    <= w_be;
            end
            // Anything that does not retire enters MEM/WB as a bubble.
            valid_out          <= w_retire;
            regwrite_MEMEX_out <= w_retire & regwrite_MEMEX_out2;
            if (w_retire) begin
                WData_MEM_out     <= WData_MEMEX_out;
                writingData_MEMWB <= w_wb_data;
            end
        end
    end

endmodule
`default_nettype wire
